strip_result_streamer: RTL
==========================

STRIP_RESULT_STREAMER -- requirements
Module: strip_result_streamer

Interface
REQ-001 Parameter N_STRIPS, default 8: number of result strips, 1..16.
REQ-002 Parameter DATA_W, default 23: signed width of one result sample.
REQ-003 Parameter ADDR_W, default 13: width of the strip read address.
REQ-004 Parameter STRIP_LEN, default 6216: samples per strip, strips 0..N_STRIPS-2.
REQ-005 Parameter LAST_LEN, default 5772: samples in strip N_STRIPS-1.
REQ-006 Parameter RD_LAT, default 2: BRAM read latency in cycles, 1..4.
REQ-007 Parameter SHIFT, default 0: arithmetic right shift applied before clamping, 0..DATA_W-9.
REQ-008 clk  in  1  system clock, rising edge.
REQ-009 reset  in  1  asynchronous, active-low reset.
REQ-010 start  in  1  level-sampled launch request, honoured in IDLE and DONE.
REQ-011 abort  in  1  synchronous cancel of the current stream.
REQ-012 busy  in  1  UART transmitter busy.
REQ-013 rd_data  in  N_STRIPS*DATA_W  flattened strip BRAM outputs; strip k occupies bits [k*DATA_W +: DATA_W].
REQ-014 rd_addr  out  ADDR_W  shared read address to all strip BRAMs.
REQ-015 rd_strip  out  clog2(N_STRIPS) (min 1)  index of the strip being read.
REQ-016 send  out  1  one-cycle UART launch pulse.
REQ-017 transmit_data  out  8  byte for UART.
REQ-018 strip_done  out  N_STRIPS  sticky per-strip completion flags.
REQ-019 all_done  out  1  high while in DONE.
REQ-020 active  out  1  high in any state other than IDLE and DONE.

Function
REQ-021 States SHALL be IDLE, ADDR, WAIT_RD, LOAD, TX, NEXT and DONE.
REQ-022 IDLE: start=1 -> ADDR with addr=0, strip=0, strip_done cleared.
REQ-023 ADDR: rd_addr=addr and rd_strip=strip are registered and held until the next ADDR; -> WAIT_RD.
REQ-024 WAIT_RD: stays exactly RD_LAT cycles counted from the ADDR cycle; -> LOAD.
REQ-025 LOAD: captures slice rd_strip of rd_data as sample s and computes v = s >>> SHIFT; -> TX.
REQ-026 Conversion: byte = 0 if v<0; 255 if v>255; else v[7:0]; signed compare at full DATA_W.
REQ-027 TX, busy=1: hold state, send=0, transmit_data unchanged.
REQ-028 TX, busy=0: transmit_data=byte and send=1 for exactly one cycle; -> NEXT.
REQ-029 NEXT, addr < len(strip)-1: addr+1; -> ADDR.
REQ-030 NEXT, addr = len(strip)-1: set strip_done[strip], addr=0; if strip=N_STRIPS-1 -> DONE, else strip+1 -> ADDR.
REQ-031 Per-sample latency from ADDR to send is RD_LAT+2 cycles with busy low; no sample is skipped or duplicated.
REQ-032 DONE: all_done=1; start=1 -> behaves as start in IDLE (clears strip_done, restarts at strip 0).
REQ-033 abort=1 in any state except IDLE -> IDLE next cycle; send=0; addr/strip cleared; strip_done retained; abort takes priority over start and over busy.
REQ-034 start is ignored while active=1.
REQ-035 send is never high in two consecutive cycles.
REQ-036 A busy rise coinciding with TX entry holds the byte until busy falls; a busy toggle during WAIT_RD has no effect.

Reset
REQ-037 reset=0 forces IDLE immediately, independent of clk.
REQ-038 Reset values: send=0, transmit_data=0, rd_addr=0, rd_strip=0, strip_done=0, all_done=0, active=0, internal counters=0.
REQ-039 Release of reset mid-stream SHALL NOT resume the stream; a new start is required.

Verification (N_STRIPS=2, STRIP_LEN=3, LAST_LEN=2, RD_LAT=2, SHIFT=0 unless stated)
REQ-040 Strip0 = {5,-7,300}, strip1 = {255,0}, busy=0, start pulse -> bytes 5,0,255,255,0 in order; strip_done=01 after the third byte and 11 after the fifth; all_done=1; send-to-send spacing 5 cycles.
REQ-041 busy held high 10 cycles at the second TX -> byte 0 is presented on send once, when busy falls; total send count is 5.
REQ-042 SHIFT=2, sample 1000 -> byte 250; sample 1100 -> 255; sample -4 -> 0.
REQ-043 abort asserted in WAIT_RD of strip1 addr 0 -> IDLE next cycle; strip_done=01; no further send; a following start restarts at strip0 addr0 with strip_done cleared.
REQ-044 reset driven low during TX with busy=1 -> send=0 and all outputs at reset values at once; after reset release with start held low, no send occurs.
REQ-045 start held high through an entire run -> after DONE is entered, a second full 5-byte stream follows; no start is honoured while active=1.

Source files
------------

// File: rtl/strip_result_streamer.sv
// Streams clamped 8-bit result samples from a bank of strip BRAMs to a UART,
// one strip after another, with start/abort control and per-strip completion flags.
module strip_result_streamer #(
  parameter int unsigned N_STRIPS  = 8,
  parameter int unsigned DATA_W    = 23,
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned STRIP_LEN = 6216,
  parameter int unsigned LAST_LEN  = 5772,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned SHIFT     = 0
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            start,
  input  logic                                            abort,
  input  logic                                            busy,
  input  logic [N_STRIPS*DATA_W-1:0]                      rd_data,
  output logic [ADDR_W-1:0]                               rd_addr,
  output logic [((N_STRIPS > 1) ? $clog2(N_STRIPS) : 1)-1:0] rd_strip,
  output logic                                            send,
  output logic [7:0]                                      transmit_data,
  output logic [N_STRIPS-1:0]                             strip_done,
  output logic                                            all_done,
  output logic                                            active
);

  localparam int unsigned STRIP_W = (N_STRIPS > 1) ? $clog2(N_STRIPS) : 1;
  // ADDR already covers one latency cycle; RD_LAT=1 still passes through WAIT_RD once
  localparam int unsigned WAIT_CYC = (RD_LAT > 1) ? RD_LAT - 1 : 1;
  localparam int unsigned CNT_W    = 3;

  localparam logic [STRIP_W-1:0] LAST_STRIP = STRIP_W'(N_STRIPS - 1);
  localparam logic [ADDR_W-1:0]  STRIP_END  = ADDR_W'(STRIP_LEN - 1);
  localparam logic [ADDR_W-1:0]  LAST_END   = ADDR_W'(LAST_LEN - 1);
  localparam logic [CNT_W-1:0]   WAIT_END   = CNT_W'(WAIT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT_RD,
    S_LOAD,
    S_TX,
    S_NEXT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     wait_q, wait_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic [ADDR_W-1:0]    rd_addr_d;
  logic [STRIP_W-1:0]   rd_strip_d;
  logic                 send_d;
  logic [7:0]           transmit_data_d;
  logic [N_STRIPS-1:0]  strip_done_d;
  logic                 all_done_d;
  logic                 active_d;

  logic signed [DATA_W-1:0] sample_c;
  logic signed [DATA_W-1:0] shifted_c;
  logic [7:0]               byte_c;
  logic [ADDR_W-1:0]        end_addr_c;

  // Select the slice of the strip currently being read
  always_comb begin
    sample_c = '0;
    for (int unsigned k = 0; k < N_STRIPS; k++) begin
      if (rd_strip == STRIP_W'(k)) begin
        sample_c = rd_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Scale and saturate to an unsigned byte using the full signed width
  always_comb begin
    shifted_c = sample_c >>> SHIFT;
    if (shifted_c[DATA_W-1]) begin
      byte_c = 8'd0;
    end else if (shifted_c > $signed(DATA_W'(255))) begin
      byte_c = 8'd255;
    end else begin
      byte_c = shifted_c[7:0];
    end
  end

  assign end_addr_c = (rd_strip == LAST_STRIP) ? LAST_END : STRIP_END;

  // Next-state and next-output logic; rd_addr/rd_strip double as the stream counters
  always_comb begin
    state_d         = state_q;
    wait_d          = wait_q;
    tx_byte_d       = tx_byte_q;
    rd_addr_d       = rd_addr;
    rd_strip_d      = rd_strip;
    send_d          = 1'b0;
    transmit_data_d = transmit_data;
    strip_done_d    = strip_done;

    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      wait_d     = '0;
      rd_addr_d  = '0;
      rd_strip_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d      = S_ADDR;
            rd_addr_d    = '0;
            rd_strip_d   = '0;
            strip_done_d = '0;
          end
        end
        S_ADDR: begin
          wait_d  = '0;
          state_d = S_WAIT_RD;
        end
        S_WAIT_RD: begin
          if (wait_q == WAIT_END) begin
            state_d = S_LOAD;
          end else begin
            wait_d = wait_q + CNT_W'(1);
          end
        end
        S_LOAD: begin
          tx_byte_d = byte_c;
          state_d   = S_TX;
        end
        S_TX: begin
          if (!busy) begin
            transmit_data_d = tx_byte_q;
            send_d          = 1'b1;
            state_d         = S_NEXT;
          end
        end
        S_NEXT: begin
          if (rd_addr == end_addr_c) begin
            strip_done_d[rd_strip] = 1'b1;
            rd_addr_d              = '0;
            if (rd_strip == LAST_STRIP) begin
              state_d = S_DONE;
            end else begin
              rd_strip_d = rd_strip + STRIP_W'(1);
              state_d    = S_ADDR;
            end
          end else begin
            rd_addr_d = rd_addr + ADDR_W'(1);
            state_d   = S_ADDR;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    all_done_d = (state_d == S_DONE);
    active_d   = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      wait_q        <= '0;
      tx_byte_q     <= '0;
      rd_addr       <= '0;
      rd_strip      <= '0;
      send          <= 1'b0;
      transmit_data <= '0;
      strip_done    <= '0;
      all_done      <= 1'b0;
      active        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      tx_byte_q     <= tx_byte_d;
      rd_addr       <= rd_addr_d;
      rd_strip      <= rd_strip_d;
      send          <= send_d;
      transmit_data <= transmit_data_d;
      strip_done    <= strip_done_d;
      all_done      <= all_done_d;
      active        <= active_d;
    end
  end

endmodule
